// File: rtl/magic_seq.sv
// Microprogrammed MAGIC crossbar sequencer: walks a NOR/NOT gate list and issues INIT/EVAL commands.
// Define MAGIC_BATCH_INIT_EN to issue every output INIT back-to-back up front instead of per gate.
module magic_seq #(
  parameter int N_GATES    = 16,
  parameter int COL_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(N_GATES)-1:0] prog_addr,
  input  logic [3*COL_W:0]           prog_data,
  input  logic [$clog2(N_GATES):0]   prog_len,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       xb_valid,
  input  logic                       xb_ready,
  output logic [1:0]                 xb_cmd,
  output logic [COL_W-1:0]           xb_in1,
  output logic [COL_W-1:0]           xb_in2,
  output logic [COL_W-1:0]           xb_out
);
  localparam int IW = $clog2(N_GATES);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IW:0]   LEN_MAX  = (IW+1)'(N_GATES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_I, S_EVAL, S_WAIT_E, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW:0]      len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [3*COL_W:0] store_q [N_GATES];
  logic             g_op;
  logic [COL_W-1:0] g_in1, g_in2, g_out;
  logic             last, settled;

  assign {g_op, g_in1, g_in2, g_out} = store_q[idx_q];
  assign last    = ({1'b0, idx_q} + {{IW{1'b0}}, 1'b1}) == len_q;
  assign settled = (cnt_q == CNT_LAST);
  assign err     = err_q;

  // Program store is plain storage: writes only land while the sequencer is not running.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) store_q[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    xb_valid = 1'b0;
    xb_cmd   = 2'b00;
    xb_in1   = '0;
    xb_in2   = '0;
    xb_out   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (prog_len == '0) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        busy     = 1'b1;
        xb_valid = 1'b1;
        xb_cmd   = 2'b01;
        xb_out   = g_out;
        if (xb_ready) begin
`ifdef MAGIC_BATCH_INIT_EN
          if (last) begin
            idx_d   = '0;
            state_d = S_WAIT_I;
          end else begin
            idx_d   = idx_q + IW'(1);
          end
`else
          state_d = S_WAIT_I;
`endif
        end
      end
      S_WAIT_I: begin
        busy = 1'b1;
        if (settled) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_EVAL: begin
        busy     = 1'b1;
        xb_valid = 1'b1;
        xb_cmd   = g_op ? 2'b11 : 2'b10;
        xb_in1   = g_in1;
        xb_in2   = g_op ? '0 : g_in2;
        xb_out   = g_out;
        if (xb_ready) state_d = S_WAIT_E;
      end
      S_WAIT_E: begin
        busy = 1'b1;
        if (settled) begin
          cnt_d = '0;
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
`ifdef MAGIC_BATCH_INIT_EN
            state_d = S_EVAL;
`else
            state_d = S_INIT;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = prog_we && busy;
  end
endmodule
